// File: rtl/alt_vipvfr121_frame_read_cmd_gen.sv
// Frame-read sequencer: splits lines into read bursts, paces them by
// read-FIFO credit and streams returned words out with eol/eof tags.
module alt_vipvfr121_frame_read_cmd_gen #(
   parameter int ADDR_WIDTH                     = 32,
   parameter int DATA_WIDTH                     = 16,
   parameter int MAX_BURST_LENGTH_REQUIREDWIDTH = 11,
   parameter int MAX_BURST                      = 32,
   parameter int READ_FIFO_DEPTH                = 64,
   parameter int WORDS_WIDTH                    = 12
) (
   input  logic                                      clock,
   input  logic                                      reset,
   input  logic                                      start,
   input  logic [ADDR_WIDTH-1:0]                     base_addr,
   input  logic [WORDS_WIDTH-1:0]                    line_words,
   input  logic [WORDS_WIDTH-1:0]                    line_count,
   input  logic [ADDR_WIDTH-1:0]                     line_stride,
   output logic                                      busy,
   output logic                                      done,
   output logic [ADDR_WIDTH-1:0]                     addr,
   output logic                                      command,
   output logic                                      is_burst,
   output logic                                      is_write_not_read,
   output logic [MAX_BURST_LENGTH_REQUIREDWIDTH-1:0] burst_length,
   output logic                                      read,
   input  logic [DATA_WIDTH-1:0]                     readdata,
   input  logic                                      stall,
   output logic [DATA_WIDTH-1:0]                     dout_data,
   output logic                                      dout_valid,
   input  logic                                      dout_ready,
   output logic                                      dout_eol,
   output logic                                      dout_eof
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int BLW   = MAX_BURST_LENGTH_REQUIREDWIDTH;
   localparam int WW    = WORDS_WIDTH;
   localparam int AW    = ADDR_WIDTH;
   localparam int CW    = $clog2(READ_FIFO_DEPTH + MAX_BURST + 1) + 1;

   typedef enum logic [1:0] {S_IDLE, S_CMD, S_DRAIN} state_t;

   state_t          state_q;
   logic            done_q, cmd_q, stall_q, read_q;
   logic [AW-1:0]   addr_q, line_start_q, stride_q;
   logic [BLW-1:0]  bl_q;
   logic [WW-1:0]   lw_q, lc_q, rem_q, lines_q;
   logic [WW-1:0]   rd_col_q, rd_line_q;
   logic [CW-1:0]   out_q;
   logic            infl_q, infl_eol_q, infl_eof_q;
   logic [DATA_WIDTH-1:0] buf_data_q [2];
   logic            buf_eol_q [2];
   logic            buf_eof_q [2];
   logic            wr_ptr_q, rd_ptr_q;
   logic [1:0]      cnt_q;

   logic            cmd_acc, rd_acc, pop, read_calc, read_d;
   logic            rd_eol, rd_eof, last_burst, fit_nxt, fit_cur;
   logic [CW-1:0]   out_d;
   logic [AW-1:0]   nxt_addr, nxt_ls;
   logic [BLW-1:0]  nxt_bl;
   logic [WW-1:0]   nxt_rem, nxt_lines;

   function automatic logic [BLW-1:0] clip(input logic [WW-1:0] w);
      if (w > WW'(MAX_BURST)) return BLW'(MAX_BURST);
      return BLW'(w);
   endfunction

   // Handshakes, read pacing and credit bookkeeping
   always_comb begin
      cmd_acc   = cmd_q & ~stall;
      pop       = (cnt_q != 2'd0) & dout_ready;
      read_calc = (out_q != '0) &&
                  (({1'b0, cnt_q} + {2'b0, infl_q} - {2'b0, pop}) < 3'd2);
      read_d    = stall_q ? read_q : read_calc;
      rd_acc    = read_d & ~stall;
      out_d     = out_q + (cmd_acc ? CW'(bl_q) : CW'(0)) - CW'(rd_acc);
      rd_eol    = (rd_col_q == lw_q - WW'(1));
      rd_eof    = rd_eol && (rd_line_q == lc_q - WW'(1));
   end

   // Next burst: continue the line, or jump to the next line start
   always_comb begin
      last_burst = (rem_q == '0) && (lines_q == '0);
      nxt_ls     = line_start_q;
      nxt_addr   = addr_q + AW'(bl_q) * AW'(BYTES);
      nxt_bl     = clip(rem_q);
      nxt_rem    = rem_q - WW'(clip(rem_q));
      nxt_lines  = lines_q;
      if (rem_q == '0) begin
         nxt_ls    = line_start_q + stride_q;
         nxt_addr  = line_start_q + stride_q;
         nxt_bl    = clip(lw_q);
         nxt_rem   = lw_q - WW'(clip(lw_q));
         nxt_lines = lines_q - WW'(1);
      end
      fit_nxt = (out_d + CW'(nxt_bl)) <= CW'(READ_FIFO_DEPTH);
      fit_cur = (out_d + CW'(bl_q)) <= CW'(READ_FIFO_DEPTH);
   end

   // Sequencer, read tracking and 2-entry output buffer
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         done_q       <= 1'b0;
         cmd_q        <= 1'b0;
         stall_q      <= 1'b0;
         read_q       <= 1'b0;
         addr_q       <= '0;
         line_start_q <= '0;
         stride_q     <= '0;
         bl_q         <= '0;
         lw_q         <= '0;
         lc_q         <= '0;
         rem_q        <= '0;
         lines_q      <= '0;
         rd_col_q     <= '0;
         rd_line_q    <= '0;
         out_q        <= '0;
         infl_q       <= 1'b0;
         infl_eol_q   <= 1'b0;
         infl_eof_q   <= 1'b0;
         buf_data_q[0] <= '0;
         buf_data_q[1] <= '0;
         buf_eol_q[0] <= 1'b0;
         buf_eol_q[1] <= 1'b0;
         buf_eof_q[0] <= 1'b0;
         buf_eof_q[1] <= 1'b0;
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
         cnt_q        <= 2'd0;
      end else begin
         done_q     <= 1'b0;
         stall_q    <= stall;
         read_q     <= read_d;
         out_q      <= out_d;
         infl_q     <= rd_acc;
         infl_eol_q <= rd_acc & rd_eol;
         infl_eof_q <= rd_acc & rd_eof;
         if (rd_acc) begin
            if (rd_eol) begin
               rd_col_q  <= '0;
               rd_line_q <= rd_line_q + WW'(1);
            end else begin
               rd_col_q  <= rd_col_q + WW'(1);
            end
         end
         if (infl_q) begin
            buf_data_q[wr_ptr_q] <= readdata;
            buf_eol_q[wr_ptr_q]  <= infl_eol_q;
            buf_eof_q[wr_ptr_q]  <= infl_eof_q;
            wr_ptr_q             <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         cnt_q <= cnt_q + {1'b0, infl_q} - {1'b0, pop};
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (line_words == '0 || line_count == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     state_q      <= S_CMD;
                     cmd_q        <= 1'b1;
                     addr_q       <= base_addr;
                     line_start_q <= base_addr;
                     stride_q     <= line_stride;
                     lw_q         <= line_words;
                     lc_q         <= line_count;
                     bl_q         <= clip(line_words);
                     rem_q        <= line_words - WW'(clip(line_words));
                     lines_q      <= line_count - WW'(1);
                     rd_col_q     <= '0;
                     rd_line_q    <= '0;
                  end
               end
            end
            S_CMD: begin
               if (!stall) begin
                  if (cmd_q) begin
                     if (last_burst) begin
                        cmd_q   <= 1'b0;
                        state_q <= S_DRAIN;
                     end else begin
                        addr_q       <= nxt_addr;
                        line_start_q <= nxt_ls;
                        bl_q         <= nxt_bl;
                        rem_q        <= nxt_rem;
                        lines_q      <= nxt_lines;
                        cmd_q        <= fit_nxt;
                     end
                  end else begin
                     cmd_q <= fit_cur;
                  end
               end
            end
            S_DRAIN: begin
               if (pop && buf_eof_q[rd_ptr_q]) begin
                  state_q <= S_IDLE;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy              = (state_q != S_IDLE);
   assign done              = done_q;
   assign addr              = addr_q;
   assign command           = cmd_q;
   assign is_burst          = 1'b1;
   assign is_write_not_read = 1'b0;
   assign burst_length      = bl_q;
   assign read              = read_d;
   assign dout_valid        = (cnt_q != 2'd0);
   assign dout_data         = buf_data_q[rd_ptr_q];
   assign dout_eol          = dout_valid & buf_eol_q[rd_ptr_q];
   assign dout_eof          = dout_valid & buf_eof_q[rd_ptr_q];

endmodule

// File: tb/tb_alt_vipvfr121_frame_read_cmd_gen.sv
// Bench: bursting-master model plus frame scoreboard built from line/burst
// arithmetic; directed and random-stall frames.
module tb_alt_vipvfr121_frame_read_cmd_gen;

   localparam int DEPTH = 64;

   logic        clock = 0, reset = 0, start = 0;
   logic [31:0] base_addr = 0, line_stride = 0;
   logic [11:0] line_words = 0, line_count = 0;
   logic [15:0] readdata = 0;
   logic        stall = 0, dout_ready = 1;
   logic        busy, done, command, is_burst, is_write_not_read, read;
   logic [31:0] addr;
   logic [10:0] burst_length;
   logic [15:0] dout_data;
   logic        dout_valid, dout_eol, dout_eof;

   alt_vipvfr121_frame_read_cmd_gen dut (
      .clock(clock), .reset(reset), .start(start),
      .base_addr(base_addr), .line_words(line_words),
      .line_count(line_count), .line_stride(line_stride),
      .busy(busy), .done(done), .addr(addr), .command(command),
      .is_burst(is_burst), .is_write_not_read(is_write_not_read),
      .burst_length(burst_length), .read(read), .readdata(readdata),
      .stall(stall), .dout_data(dout_data), .dout_valid(dout_valid),
      .dout_ready(dout_ready), .dout_eol(dout_eol), .dout_eof(dout_eof)
   );

   always #5 clock = ~clock;

   typedef struct { logic [31:0] a; int len; } cmd_t;
   typedef struct { logic [15:0] d; logic eol; logic eof; } word_t;

   cmd_t        exp_cmd[$];
   word_t       exp_w[$];
   logic [31:0] mq[$];
   int vecs = 0, errs = 0;
   int n_cmd, n_rd, n_done, exp_ncmd, first_chk = 0;
   int stall_mode = 0, ready_mode = 0, ready_block = 0;
   logic [31:0] cur_base, prev_addr;
   logic [10:0] prev_bl;
   logic prev_stall = 0, prev_cmd = 0, prev_read = 0, prev_done = 0;
   logic rd_pending = 0;
   logic [15:0] rd_val;

   function automatic logic [15:0] wdata(input logic [31:0] a);
      return a[16:1] ^ a[31:16] ^ 16'h5A3C;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] want);
      vecs++;
      assert (got === want) else begin
         errs++;
         $error("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   // one clock: sample/score at negedge, drive after posedge
   task automatic step();
      cmd_t c;
      word_t w;
      @(negedge clock);
      if (first_chk == 1) begin
         chk("first_busy", 64'(busy), 1);
         chk("first_cmd", 64'(command), 1);
         chk("first_addr", 64'(addr), 64'(cur_base));
      end else if (first_chk == 2) begin
         chk("zero_busy", 64'(busy), 0);
         chk("zero_cmd", 64'(command), 0);
      end
      first_chk = 0;
      if (prev_stall && prev_cmd) begin
         chk("hold_cmd", 64'(command), 1);
         chk("hold_addr", 64'(addr), 64'(prev_addr));
         chk("hold_len", 64'(burst_length), 64'(prev_bl));
      end
      if (prev_stall) chk("hold_read", 64'(read), 64'(prev_read));
      if (command && !stall) begin
         n_cmd++;
         chk("cmd_expected", 64'(exp_cmd.size() != 0), 1);
         if (exp_cmd.size() != 0) begin
            c = exp_cmd.pop_front();
            chk("cmd_addr", 64'(addr), 64'(c.a));
            chk("cmd_len", 64'(burst_length), 64'(c.len));
         end
         for (int i = 0; i < int'(burst_length); i++)
            mq.push_back(addr + 32'(2 * i));
         chk("credit", 64'(mq.size() <= DEPTH), 1);
      end
      if (read && !stall) begin
         n_rd++;
         chk("read_has_data", 64'(mq.size() != 0), 1);
         if (mq.size() != 0) begin
            rd_val = wdata(mq.pop_front());
            rd_pending = 1;
         end
      end
      if (dout_valid && dout_ready) begin
         chk("word_expected", 64'(exp_w.size() != 0), 1);
         if (exp_w.size() != 0) begin
            w = exp_w.pop_front();
            chk("word", 64'({dout_data, dout_eol, dout_eof}),
                64'({w.d, w.eol, w.eof}));
         end
      end
      if (done) begin
         n_done++;
         chk("done_pulse", 64'(prev_done), 0);
      end
      prev_stall = stall; prev_cmd = command; prev_read = read;
      prev_addr = addr; prev_bl = burst_length; prev_done = done;
      @(posedge clock);
      #1;
      readdata = rd_pending ? rd_val : 16'($urandom);
      rd_pending = 0;
      stall = (stall_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      dout_ready = (ready_block != 0) ? 1'b0 :
                   (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   task automatic kick(input logic [31:0] b, input int lw, input int lc,
                       input logic [31:0] s);
      logic [31:0] ls;
      int len;
      exp_cmd.delete();
      exp_w.delete();
      for (int l = 0; l < lc; l++) begin
         ls = b + 32'(l) * s;
         for (int w = 0; w < lw; w += 32) begin
            len = (lw - w < 32) ? lw - w : 32;
            exp_cmd.push_back('{a: ls + 32'(2 * w), len: len});
         end
         for (int w = 0; w < lw; w++)
            exp_w.push_back('{d: wdata(ls + 32'(2 * w)), eol: (w == lw - 1),
                              eof: (w == lw - 1) && (l == lc - 1)});
      end
      n_cmd = 0; n_rd = 0; n_done = 0;
      exp_ncmd = exp_cmd.size();
      cur_base = b;
      base_addr = b; line_words = 12'(lw);
      line_count = 12'(lc); line_stride = s;
      start = 1;
      step();
      start = 0;
      first_chk = (lw == 0 || lc == 0) ? 2 : 1;
   endtask

   task automatic finish_frame(input int poke_at, input int hold,
                               input int hold_cmds);
      int k;
      for (k = 0; k < 6000; k++) begin
         if (k == poke_at) begin
            start = 1; base_addr = 32'h00AB_C000;
            line_words = 12'd7; line_count = 12'd3;
         end
         if (k == poke_at + 1) start = 0;
         if (hold > 0 && k == 0) begin
            ready_block = 1; dout_ready = 0;
         end
         if (hold > 0 && k == hold) begin
            chk("bp_cmds", 64'(n_cmd), 64'(hold_cmds));
            chk("bp_reads", 64'(n_rd), 2);
            chk("bp_cmd_low", 64'(command), 0);
            ready_block = 0;
         end
         step();
         if (n_done != 0) break;
      end
      if (exp_ncmd == 0) chk("zero_latency", 64'(k), 0);
      chk("frame_done", 64'(n_done), 1);
      chk("cmd_count", 64'(n_cmd), 64'(exp_ncmd));
      chk("words_left", 64'(exp_w.size()), 0);
      chk("busy_after", 64'(busy), 0);
      repeat (4) step();
      chk("no_extra_done", 64'(n_done), 1);
      chk("no_extra_cmd", 64'(n_cmd), 64'(exp_ncmd));
   endtask

   initial begin
      reset = 0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_ctl", 64'({command, read, busy, done, dout_valid,
                          dout_eol, dout_eof}), 0);
      chk("rst_addr", 64'(addr), 0);
      chk("rst_len", 64'(burst_length), 0);
      chk("rst_data", 64'(dout_data), 0);
      chk("rst_consts", 64'({is_burst, is_write_not_read}), 64'(2'b10));
      @(posedge clock);
      #1 reset = 1;

      kick(32'h1000, 80, 2, 32'h200);
      finish_frame(-10, 0, 0);
      kick(32'h1000, 80, 2, 32'h200);
      finish_frame(5, 0, 0);
      kick(32'h1000, 80, 2, 32'h200);
      finish_frame(-10, 60, 2);
      kick(32'h4000, 0, 3, 32'h100);
      finish_frame(-10, 0, 0);
      kick(32'h4000, 5, 0, 32'h100);
      finish_frame(-10, 0, 0);

      kick(32'h2000, 80, 2, 32'h200);
      repeat (25) step();
      reset = 0;
      step();
      reset = 1;
      @(negedge clock);
      chk("mid_rst_ctl", 64'({command, read, busy, done, dout_valid,
                              dout_eol, dout_eof}), 0);
      chk("mid_rst_addr", 64'(addr), 0);
      chk("mid_rst_len", 64'(burst_length), 0);
      mq.delete();
      prev_stall = 0; prev_cmd = 0; prev_read = 0; prev_done = 0;
      rd_pending = 0;
      @(posedge clock);
      #1;
      kick(32'h3000, 40, 3, 32'h100);
      finish_frame(-10, 0, 0);

      stall_mode = 1; ready_mode = 1;
      kick(32'h1000, 80, 2, 32'h200);
      finish_frame(-10, 0, 0);
      for (int f = 0; f < 4; f++) begin
         kick($urandom & 32'hFFFF_FFFE, $urandom_range(1, 100),
              $urandom_range(1, 4), 32'($urandom_range(0, 255)) * 2);
         finish_frame(-10, 0, 0);
      end
      kick(32'hFFFF_FF00, 100, 2, 32'h80);
      finish_frame(-10, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
